// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_plus block.
//   fifo_mode_e : read-port mode (registered read or first-word-fall-through)
//   cnt_w()     : width of the occupancy count for a given depth (0..DEPTH)
//   ptr_w()     : width of a read/write pointer for a given depth
package fifo_pkg;

  typedef enum logic {
    MODE_REG  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_plus_if.sv
// Handshake/status bundle for fifo_plus.
//   master : producer/consumer side (drives push/pop/flush/clear_err/data_in)
//   slave  : the FIFO (drives data_out, status flags, count, sticky errors)
interface fifo_plus_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) ();

  logic                      push;
  logic [WIDTH-1:0]          data_in;
  logic                      pop;
  logic                      flush;
  logic                      clear_err;
  logic [WIDTH-1:0]          data_out;
  logic                      full;
  logic                      empty;
  logic                      almost_full;
  logic                      almost_empty;
  logic [cnt_w(DEPTH)-1:0]   count;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output push, data_in, pop, flush, clear_err,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  push, data_in, pop, flush, clear_err,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Storage array for fifo_plus: DEPTH words of WIDTH bits.
//   clock   : write clock
//   i_we    : write enable, i_waddr/i_wdata written on the rising edge
//   i_raddr : asynchronous read address, o_rdata follows it combinationally
// Contents are deliberately not reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic [PW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [PW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_plus.sv
// fifo_plus: single-clock FIFO with registered-read or FWFT output,
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags.
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : fifo_plus_if.slave (push/pop/flush/clear_err/data_in in,
//            data_out/flags/count/errors out)
// Pointers, count, flags and the registered data_out live here; the array
// lives in fifo_mem. All flags decode the registered count only.
module fifo_plus
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic        clock,
  input  logic        resetn,
  fifo_plus_if.slave  bus
);

  localparam int         CW   = cnt_w(DEPTH);
  localparam int         PW   = ptr_w(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? MODE_FWFT : MODE_REG;

  // Elaboration-time parameter sanity
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_plus: DEPTH must be >= 2");
  end
  if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_lvl
    $error("fifo_plus: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf, r_unf;
  logic             w_full, w_empty;
  logic             w_pop_ok, w_push_ok;
  logic             w_ovf_set, w_unf_set;
  logic [WIDTH-1:0] w_rdata;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Flush wins over everything; a pop frees the slot a same-cycle push
  // needs when full.
  assign w_pop_ok  = bus.pop  && !w_empty && !bus.flush;
  assign w_push_ok = bus.push && (!w_full || w_pop_ok) && !bus.flush;
  assign w_ovf_set = bus.push && !w_push_ok && !bus.flush;
  assign w_unf_set = bus.pop  && w_empty    && !bus.flush;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= inc_ptr(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= inc_ptr(r_rd_ptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky errors: a new error beats a same-cycle clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_ovf_set)          r_ovf <= 1'b1;
      else if (bus.clear_err) r_ovf <= 1'b0;
      if (w_unf_set)          r_unf <= 1'b1;
      else if (bus.clear_err) r_unf <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clock   (clock),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  if (MODE == MODE_FWFT) begin : g_fwft
    // Head word straight from the array; a fresh write only shows after
    // the edge that stored it, so there is no input-to-output path.
    assign bus.data_out = w_empty ? '0 : w_rdata;
  end else begin : g_reg
    logic [WIDTH-1:0] r_dout;
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)       r_dout <= '0;
      else if (w_pop_ok) r_dout <= w_rdata;
    end
    assign bus.data_out = r_dout;
  end

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= CW'(AF_LEVEL));
  assign bus.almost_empty = (r_count <= CW'(AE_LEVEL));
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;

endmodule

// File: tb/tb_fifo_plus.sv
// Bench for fifo_plus: a registered-read and an FWFT instance share the same
// stimulus and are compared every cycle against a queue-based model.
module tb_fifo_plus;
  import fifo_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  fifo_plus_if #(.WIDTH(W), .DEPTH(D)) b0 ();
  fifo_plus_if #(.WIDTH(W), .DEPTH(D)) b1 ();

  fifo_plus #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE))
    u_reg  (.clock(clock), .resetn(resetn), .bus(b0));
  fifo_plus #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE))
    u_fwft (.clock(clock), .resetn(resetn), .bus(b1));

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference model
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout;
  bit           m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit pu, input logic [W-1:0] d, input bit po,
                       input bit fl, input bit cl);
    b0.push = pu; b0.data_in = d; b0.pop = po; b0.flush = fl; b0.clear_err = cl;
    b1.push = pu; b1.data_in = d; b1.pop = po; b1.flush = fl; b1.clear_err = cl;
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count",     32'(b0.count),        32'(n));
    chk("empty",     32'(b0.empty),        32'(n == 0));
    chk("full",      32'(b0.full),         32'(n == D));
    chk("afull",     32'(b0.almost_full),  32'(n >= AF));
    chk("aempty",    32'(b0.almost_empty), 32'(n <= AE));
    chk("overflow",  32'(b0.overflow),     32'(m_ovf));
    chk("underflow", 32'(b0.underflow),    32'(m_unf));
    chk("dout_reg",  32'(b0.data_out),     32'(m_dout));
    chk("dout_fwft", 32'(b1.data_out),     (n == 0) ? 32'd0 : 32'(q[0]));
    chk("count_fwft",32'(b1.count),        32'(n));
    chk("empty_fwft",32'(b1.empty),        32'(n == 0));
  endtask

  // One clock: apply inputs, advance model at the edge, check 1ns later.
  task automatic step(input bit pu, input logic [W-1:0] d, input bit po,
                      input bit fl, input bit cl);
    bit pop_ok, push_ok;
    drive(pu, d, po, fl, cl);
    @(posedge clock);
    if (fl) begin
      q.delete();
      if (cl) begin m_ovf = 1'b0; m_unf = 1'b0; end
    end else begin
      pop_ok  = po && (q.size() > 0);
      push_ok = pu && ((q.size() < D) || pop_ok);
      if (pu && !push_ok)           m_ovf = 1'b1;
      else if (cl)                  m_ovf = 1'b0;
      if (po && q.size() == 0)      m_unf = 1'b1;
      else if (cl)                  m_unf = 1'b0;
      if (pop_ok)  m_dout = q.pop_front();
      if (push_ok) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    drive(0, '0, 0, 0, 0);
    #12;
    check_all();                       // values while held in reset
    resetn = 1'b1;
    step(0, '0, 0, 0, 0);              // idle after reset

    // Fill past full: 1..4 then 5,6 dropped
    for (int i = 1; i <= 6; i++) step(1, W'(i), 0, 0, 0);
    for (int i = 0; i < 4; i++)  step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 1);              // clear overflow

    // Full FIFO, simultaneous push+pop for 6 cycles (pointer wrap)
    for (int i = 1; i <= 4; i++) step(1, W'(i), 0, 0, 0);
    for (int i = 0; i < 6; i++)  step(1, W'(9 + i), 1, 0, 0);
    for (int i = 0; i < 4; i++)  step(0, '0, 1, 0, 0);

    // Pop on empty, clear, FWFT push into empty
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 1);
    step(1, 8'hA5, 0, 0, 0);
    step(0, '0, 1, 0, 0);

    // Error and clear in same cycle keeps flag
    step(0, '0, 1, 0, 1);
    step(0, '0, 0, 0, 1);

    // Flush with 3 entries, push/pop ignored during flush
    for (int i = 1; i <= 3; i++) step(1, W'(i + 32), 0, 0, 0);
    step(1, 8'h77, 1, 1, 0);
    step(1, 8'h44, 0, 0, 0);
    step(0, '0, 1, 0, 0);

    // Async reset between edges
    for (int i = 1; i <= 3; i++) step(1, W'(i), 0, 0, 0);
    #2 resetn = 1'b0;
    #1 model_reset();
    check_all();
    #3 resetn = 1'b1;
    step(1, 8'h07, 0, 0, 0);
    step(0, '0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 55, W'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 3,  $urandom_range(0, 99) < 5);
    end

    drive(0, '0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
